// File: rtl/cv32e40p_rvfi_retire_sched_if.sv
// Retirement stream bundle between the RVFI source, the retire scheduler
// and the trace consumer.
//   in_*  : one retirement packet per cycle from the core, no backpressure.
//   out_* : head of the scheduler FIFO towards the consumer.
// Handshake: out_valid_o/out_ready_i follow strict valid/ready rules. A
// transfer happens on every rising clock edge where both are high. Once
// out_valid_o is raised, the head entry stays stable until it is
// transferred (or until a flush/reset). in_valid_i has no ready and is
// never stalled.
// Modports:
//   slave  : scheduler side (takes in_*, drives out_*).
//   master : environment side (drives in_* and out_ready_i).
interface cv32e40p_rvfi_retire_sched_if #(
  parameter int PKT_W   = 256,
  parameter int ORDER_W = 64
);
  logic               in_valid_i;
  logic [ORDER_W-1:0] in_order_i;
  logic [PKT_W-1:0]   in_pkt_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [ORDER_W-1:0] out_order_o;
  logic [PKT_W-1:0]   out_pkt_o;

  modport slave (
    input  in_valid_i, in_order_i, in_pkt_i, out_ready_i,
    output out_valid_o, out_order_o, out_pkt_o
  );

  modport master (
    output in_valid_i, in_order_i, in_pkt_i, out_ready_i,
    input  out_valid_o, out_order_o, out_pkt_o
  );
endinterface

// File: rtl/cv32e40p_rvfi_retire_sched.sv
// Retirement scheduler: buffers RVFI retirement packets in order, drains
// them to a consumer over valid/ready, checks rvfi_order contiguity and
// sequences drain/flush requests.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset.
//   bus           : retirement stream (slave side), see the interface file.
//   drain_req_i   : level request to drain; drain_ack_o pulses once when empty.
//   flush_i       : discard every buffered entry (highest priority).
//   clr_err_i     : clear the sticky overflow_o / order_err_o flags.
//   count_o       : occupancy.
//   expected_order_o : next rvfi_order the checker expects.
//   dbg_state_o   : drain FSM state (0 RUN, 1 DRAIN, 2 ACK, 3 WAIT).
module cv32e40p_rvfi_retire_sched #(
  parameter int DEPTH   = 4,
  parameter int PKT_W   = 256,
  parameter int ORDER_W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cv32e40p_rvfi_retire_sched_if.slave bus,
  input  logic               drain_req_i,
  output logic               drain_ack_o,
  input  logic               flush_i,
  input  logic               clr_err_i,
  output logic [CW-1:0]      count_o,
  output logic               overflow_o,
  output logic               order_err_o,
  output logic [ORDER_W-1:0] expected_order_o,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  state_e             state_q;
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      count_q;
  logic [PKT_W-1:0]   pkt_mem [DEPTH];
  logic [ORDER_W-1:0] ord_mem [DEPTH];

  logic full, pop, push, drop_ovf, order_bad;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = bus.out_valid_o & bus.out_ready_i;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign push      = bus.in_valid_i & ~flush_i & (~full | pop);
  // Drops caused by a flush are intentional and do not count as overflow.
  assign drop_ovf  = bus.in_valid_i & ~flush_i & full & ~pop;
  assign order_bad = bus.in_valid_i & (bus.in_order_i != expected_order_o);

  assign bus.out_valid_o = (count_q != '0);
  assign bus.out_pkt_o   = pkt_mem[rptr_q];
  assign bus.out_order_o = ord_mem[rptr_q];
  assign count_o         = count_q;
  assign dbg_state_o     = state_q;

  // Storage array: no reset, contents are only meaningful under count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pkt_mem[wptr_q] <= bus.in_pkt_i;
      ord_mem[wptr_q] <= bus.in_order_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Order checker and sticky flags. A set event beats a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      expected_order_o <= ORDER_W'(1);
      overflow_o       <= 1'b0;
      order_err_o      <= 1'b0;
    end else begin
      // Resynchronise on every retirement so one gap gives one error event.
      if (bus.in_valid_i) expected_order_o <= bus.in_order_i + ORDER_W'(1);
      if (drop_ovf)       overflow_o <= 1'b1;
      else if (clr_err_i) overflow_o <= 1'b0;
      if (order_bad)      order_err_o <= 1'b1;
      else if (clr_err_i) order_err_o <= 1'b0;
    end
  end

  // Drain sequencer with registered ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      drain_ack_o <= 1'b0;
    end else begin
      drain_ack_o <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (drain_req_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (flush_i) begin
            state_q     <= ST_ACK;
            drain_ack_o <= 1'b1;
          end else if (!drain_req_i) begin
            state_q <= ST_RUN;
          end else if (count_q == '0 && !push) begin
            state_q     <= ST_ACK;
            drain_ack_o <= 1'b1;
          end
        end
        ST_ACK: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Hold until the request drops so a held request acks only once.
          if (!drain_req_i) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_rvfi_retire_sched.sv
module tb_cv32e40p_rvfi_retire_sched;
  localparam int DEPTH   = 4;
  localparam int PKT_W   = 256;
  localparam int ORDER_W = 64;
  localparam int CW      = $clog2(DEPTH) + 1;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               drain_req, drain_ack, flush, clr_err, overflow, order_err;
  logic [CW-1:0]      count;
  logic [ORDER_W-1:0] expected_order;
  logic [1:0]         dbg_state;

  cv32e40p_rvfi_retire_sched_if #(.PKT_W(PKT_W), .ORDER_W(ORDER_W)) bus ();

  cv32e40p_rvfi_retire_sched #(.DEPTH(DEPTH), .PKT_W(PKT_W), .ORDER_W(ORDER_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus              (bus),
    .drain_req_i      (drain_req),
    .drain_ack_o      (drain_ack),
    .flush_i          (flush),
    .clr_err_i        (clr_err),
    .count_o          (count),
    .overflow_o       (overflow),
    .order_err_o      (order_err),
    .expected_order_o (expected_order),
    .dbg_state_o      (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [PKT_W-1:0] pkt_of(input logic [ORDER_W-1:0] o);
    return {o, ~o, o ^ 64'h5a5a_a5a5_0f0f_f0f0, o + 64'd7};
  endfunction

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drive_in(input logic v, input logic [ORDER_W-1:0] o);
    bus.in_valid_i = v;
    bus.in_order_i = o;
    bus.in_pkt_i   = pkt_of(o);
  endtask

  task automatic push_seq(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      drive_in(1'b1, ORDER_W'(k));
      step();
    end
    drive_in(1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    drain_req = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    bus.out_ready_i = 1'b0;
    drive_in(1'b0, '0);
    step();
    step();

    // Reset values
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_count", count, 0);
    chk("rst_ack", drain_ack, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_oerr", order_err, 0);
    chk("rst_exp", expected_order, 1);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // Pass-through: head appears one cycle after each push
    bus.out_ready_i = 1'b1;
    chk("pt_valid0", bus.out_valid_o, 0);
    for (int k = 1; k <= 3; k++) begin
      drive_in(1'b1, ORDER_W'(k));
      step();
      chk("pt_valid", bus.out_valid_o, 1);
      chk("pt_order", bus.out_order_o, k);
      chk("pt_count", count, 1);
    end
    chk("pt_pkt", bus.out_pkt_o, pkt_of(64'd3));
    drive_in(1'b0, '0);
    step();
    chk("pt_empty", bus.out_valid_o, 0);
    chk("pt_exp", expected_order, 4);
    chk("pt_ovf", overflow, 0);
    chk("pt_oerr", order_err, 0);

    // Fill and overflow
    do_reset();
    bus.out_ready_i = 1'b0;
    push_seq(1, 4);
    chk("fo_full", count, 4);
    chk("fo_ovf0", overflow, 0);
    push_seq(5, 5);
    chk("fo_count", count, 4);
    chk("fo_ovf", overflow, 1);
    chk("fo_oerr", order_err, 0);
    chk("fo_exp", expected_order, 6);
    bus.out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("fo_pop_valid", bus.out_valid_o, 1);
      chk("fo_pop_order", bus.out_order_o, k);
      step();
    end
    chk("fo_empty", bus.out_valid_o, 0);
    chk("fo_ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop
    do_reset();
    bus.out_ready_i = 1'b0;
    push_seq(1, 4);
    chk("fp_head", bus.out_order_o, 1);
    bus.out_ready_i = 1'b1;
    push_seq(5, 5);
    chk("fp_count", count, 4);
    chk("fp_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("fp_pop_order", bus.out_order_o, k);
      step();
    end
    chk("fp_empty", count, 0);

    // Order gap, clear, and set-beats-clear
    do_reset();
    bus.out_ready_i = 1'b1;
    push_seq(1, 2);
    chk("og_ok", order_err, 0);
    push_seq(4, 4);
    chk("og_err", order_err, 1);
    chk("og_exp", expected_order, 5);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("og_clr", order_err, 0);
    push_seq(5, 5);
    chk("og_after5", order_err, 0);
    chk("og_exp6", expected_order, 6);
    clr_err = 1'b1;
    push_seq(7, 7);
    clr_err = 1'b0;
    chk("og_set_wins", order_err, 1);
    chk("og_exp8", expected_order, 8);

    // Drain handshake
    do_reset();
    bus.out_ready_i = 1'b0;
    push_seq(1, 3);
    drain_req = 1'b1;
    bus.out_ready_i = 1'b1;
    step();
    chk("dr_cnt2", count, 2);
    chk("dr_state", dbg_state, 1);
    chk("dr_ack_a", drain_ack, 0);
    step();
    chk("dr_cnt1", count, 1);
    step();
    chk("dr_cnt0", count, 0);
    chk("dr_ack_b", drain_ack, 0);
    step();
    chk("dr_ack", drain_ack, 1);
    step();
    chk("dr_ack_once", drain_ack, 0);
    chk("dr_wait", dbg_state, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dr_held", drain_ack, 0);
    end
    drain_req = 1'b0;
    step();
    chk("dr_run", dbg_state, 0);
    chk("dr_ack_end", drain_ack, 0);

    // Flush with concurrent push
    do_reset();
    bus.out_ready_i = 1'b0;
    push_seq(1, 3);
    flush = 1'b1;
    drive_in(1'b1, 64'd4);
    step();
    flush = 1'b0;
    drive_in(1'b0, '0);
    chk("fl_count", count, 0);
    chk("fl_valid", bus.out_valid_o, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_exp", expected_order, 5);
    push_seq(5, 5);
    chk("fl_head", bus.out_order_o, 5);
    chk("fl_cnt1", count, 1);

    // Asynchronous reset mid-stream
    push_seq(9, 9);
    chk("ar_oerr_pre", order_err, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", bus.out_valid_o, 0);
    chk("ar_oerr", order_err, 0);
    chk("ar_exp", expected_order, 1);
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rvfi_retire_sched.md
Name: cv32e40p_rvfi_retire_sched

Overview:
- Retirement scheduler between the core's RVFI outputs and a trace consumer (tracer, ISS step-and-compare or formal checker port).
- The RVFI source emits one retirement packet per cycle with no backpressure. This block buffers packets in order and drains them to the consumer over a valid/ready handshake.
- It checks that the retirement order is contiguous, reports overflow, and sequences flush/drain requests from the testbench or debug control.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PKT_W, 256, width of the packed RVFI record (insn, pc, rs/rd, mem fields), excluding order.
- ORDER_W, 64, width of rvfi_order.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  retirement pulse (rvfi_valid).
- in_order_i  in  ORDER_W  rvfi_order of the incoming packet.
- in_pkt_i  in  PKT_W  packed record.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  consumer accepts the head entry.
- out_order_o  out  ORDER_W  order of the head entry.
- out_pkt_o  out  PKT_W  record of the head entry.
- drain_req_i  in  1  request to drain the FIFO; level, held until ack.
- drain_ack_o  out  1  one-cycle pulse when the drain is complete.
- flush_i  in  1  discard all entries immediately.
- clr_err_i  in  1  clear the sticky flags.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- overflow_o  out  1  sticky: a packet was dropped.
- order_err_o  out  1  sticky: an order gap or repeat was seen.
- expected_order_o  out  ORDER_W  next expected order.

Behaviour:
- Reset values: out_valid_o=0, count_o=0, drain_ack_o=0, overflow_o=0, order_err_o=0, expected_order_o=1. FSM is in RUN; pointers are 0.
- Storage: circular buffer with wptr/rptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
  - out_valid_o = (count != 0).
  - out_pkt_o and out_order_o read the entry at rptr; their value is undefined when out_valid_o=0.
- Pop: out_valid_o & out_ready_i. rptr+1, count-1 next cycle.
- Push: in_valid_i accepted if count<DEPTH, or if count==DEPTH and a pop happens the same cycle (write at wptr, count unchanged).
  - Data is visible at the head one cycle after the push when the FIFO was empty. There is no combinational in->out bypass.
- Overflow: in_valid_i with count==DEPTH and no pop drops the packet and sets overflow_o next cycle. FIFO contents are unchanged.
- Order check, on every in_valid_i (accepted or dropped):
  - If in_order_i != expected_order_o, set order_err_o.
  - Always expected_order_o <= in_order_i+1 (resynchronise). Addition wraps modulo 2^ORDER_W.
- Sticky flags clear on clr_err_i. If a set event coincides with clr_err_i, the set wins.
- flush_i (highest priority):
  - Next cycle wptr=rptr=0, count=0, out_valid_o=0.
  - in_valid_i in the flush cycle is dropped without setting overflow_o. The order check still applies.
  - expected_order_o is unaffected.
  - A flush in DRAIN forces the FSM to ACK.
- FSM:
  - RUN: normal operation. drain_req_i=1 -> DRAIN.
  - DRAIN:
    - in_valid_i is still accepted (drain does not gate the input). Pops continue.
    - count==0 in this cycle (no push) -> ACK. If drain_req_i falls before that -> RUN, no ack.
  - ACK: drain_ack_o=1 for exactly one cycle -> WAIT.
  - WAIT: hold until drain_req_i=0 -> RUN. This prevents repeated acks for a held request.
- drain_ack_o is registered: high only while in ACK.
- Reset asserted mid-operation returns every state immediately to the reset values; buffered packets are lost.
- Throughput: one push and one pop per cycle sustained; no bubbles when out_ready_i is held high.

Test Plan (DEPTH=4):
- Pass-through:
  - Stimulus: out_ready_i=1, push orders 1,2,3 on consecutive cycles.
  - Response: out_valid_o high for 3 cycles starting 1 cycle after the first push, out_order_o=1,2,3; count_o peaks at 1; no flags; expected_order_o=4.
- Fill and overflow:
  - Stimulus: out_ready_i=0, push orders 1..5.
  - Response: count_o=4, overflow_o=1 after the 5th push. Popping then yields 1,2,3,4 only.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full with 1..4; push 5 with out_ready_i=1 in the same cycle.
  - Response: no overflow, count_o stays 4, drain order is 1..5.
- Order gap:
  - Stimulus: push 1,2,4.
  - Response: order_err_o=1 after the third push, expected_order_o=5. clr_err_i clears it; a following push of 5 leaves it at 0.
- Drain handshake:
  - Stimulus: 3 entries queued, drain_req_i=1, out_ready_i=1.
  - Response: FIFO empties in 3 cycles, drain_ack_o is a single pulse one cycle after count_o reaches 0, and there is no second pulse while the request is held.
- Flush and reset:
  - Stimulus 1: flush_i with 3 entries and a concurrent push of order 4.
  - Response 1: count_o=0, no overflow, expected_order_o=5.
  - Stimulus 2: assert rst_i mid-stream.
  - Response 2: all outputs return to reset values asynchronously.
